// File: rtl/demux_lane_sched.sv
// Round-robin demux from one upstream FIFO into two downstream lanes.
// Popped words land on the granted lane two clocks after pop.
module demux_lane_sched (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       pop,
  input  logic       lane_full0,
  input  logic       lane_full1,
  output logic [7:0] dataOut0,
  output logic [7:0] dataOut1,
  output logic       validOut0,
  output logic       validOut1,
  output logic [1:0] state,
  output logic [7:0] sent0,
  output logic [7:0] sent1
);

  localparam int unsigned DW = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACTIVE = 2'b01,
    STALL  = 2'b10
  } state_e;

  state_e        state_q;
  logic          rr_q;
  logic          pend_q;
  logic          sel_q;
  logic [DW-1:0] data0_q, data1_q;
  logic          valid0_q, valid1_q;
  logic [DW-1:0] sent0_q, sent1_q;

  logic [1:0]    full;
  logic          gnt_ok;
  logic          gnt;

  // Grant prefers the round-robin lane, falls back to the other one.
  always_comb begin
    full   = {lane_full1, lane_full0};
    gnt_ok = ~(lane_full0 & lane_full1);
    gnt    = full[rr_q] ? ~rr_q : rr_q;
    pop    = reset & enable & ~fifo_empty & gnt_ok & (state_q != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      rr_q     <= 1'b0;
      pend_q   <= 1'b0;
      sel_q    <= 1'b0;
      data0_q  <= '0;
      data1_q  <= '0;
      valid0_q <= 1'b0;
      valid1_q <= 1'b0;
      sent0_q  <= '0;
      sent1_q  <= '0;
    end else begin
      // In-flight word is delivered regardless of enable or lane_full.
      valid0_q <= pend_q & ~sel_q;
      valid1_q <= pend_q & sel_q;
      if (pend_q && !sel_q) begin
        data0_q <= fifo_data;
        sent0_q <= sent0_q + DW'(1);
      end
      if (pend_q && sel_q) begin
        data1_q <= fifo_data;
        sent1_q <= sent1_q + DW'(1);
      end

      pend_q <= pop;
      if (pop) begin
        sel_q <= gnt;
        rr_q  <= ~gnt;
      end

      case (state_q)
        IDLE: begin
          if (enable) state_q <= ACTIVE;
        end
        ACTIVE: begin
          if (!enable)                                        state_q <= IDLE;
          else if (!fifo_empty && lane_full0 && lane_full1)   state_q <= STALL;
        end
        STALL: begin
          if (!enable)                                        state_q <= IDLE;
          else if (!lane_full0 || !lane_full1)                state_q <= ACTIVE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dataOut0  = data0_q;
  assign dataOut1  = data1_q;
  assign validOut0 = valid0_q;
  assign validOut1 = valid1_q;
  assign state     = state_q;
  assign sent0     = sent0_q;
  assign sent1     = sent1_q;

endmodule

// File: tb/tb_demux_lane_sched.sv
// Bench for demux_lane_sched: FIFO queue, timestamped delivery list model,
// directed scenarios with literal pins, then randomized traffic.
module tb_demux_lane_sched;

  logic       clk = 1'b0;
  logic       reset, enable, fifo_empty, lane_full0, lane_full1;
  logic [7:0] fifo_data;
  logic       pop, validOut0, validOut1;
  logic [7:0] dataOut0, dataOut1, sent0, sent1;
  logic [1:0] state;

  always #5 clk = ~clk;

  demux_lane_sched dut (
    .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .pop(pop), .lane_full0(lane_full0),
    .lane_full1(lane_full1), .dataOut0(dataOut0), .dataOut1(dataOut1),
    .validOut0(validOut0), .validOut1(validOut1), .state(state),
    .sent0(sent0), .sent1(sent1)
  );

  typedef struct {
    int         due;
    int         lane;
    logic [7:0] data;
  } dlv_t;

  dlv_t       dq[$];
  logic [7:0] fifo_q[$];

  int         m_state, m_rr, m_pop, m_lane;
  int         m_v[2];
  logic [7:0] m_d[2];
  int         m_s[2];

  int  cyc = 0, errors = 0, checks = 0;
  bit  checking = 0;
  int  obs_pop, obs_state, obs_v0, obs_v1;
  int  first_pop, first_val, v0_seen;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_rr = 0;
    m_v[0] = 0; m_v[1] = 0;
    m_d[0] = 8'h00; m_d[1] = 8'h00;
    m_s[0] = 0; m_s[1] = 0;
    dq.delete();
  endtask

  // One clock: drive inputs, compare every output, then advance the model.
  task automatic step(input bit r, input bit e, input bit f0, input bit f1);
    bit   full[2];
    dlv_t it;
    reset = r; enable = e; lane_full0 = f0; lane_full1 = f1;
    fifo_empty = (fifo_q.size() == 0);
    full[0] = f0; full[1] = f1;
    m_lane = full[m_rr] ? 1 - m_rr : m_rr;
    m_pop  = (r && e && !fifo_empty && !(f0 && f1) && m_state != 0) ? 1 : 0;
    #1;
    obs_pop = int'(pop); obs_state = int'(state);
    obs_v0 = int'(validOut0); obs_v1 = int'(validOut1);
    chk("pop", obs_pop, m_pop);
    if (checking) begin
      chk("state", obs_state, m_state);
      chk("validOut0", obs_v0, m_v[0]);
      chk("validOut1", obs_v1, m_v[1]);
      chk("dataOut0", int'(dataOut0), int'(m_d[0]));
      chk("dataOut1", int'(dataOut1), int'(m_d[1]));
      chk("sent0", int'(sent0), m_s[0]);
      chk("sent1", int'(sent1), m_s[1]);
      chk("valid_onehot", int'(validOut0 & validOut1), 0);
    end
    if (obs_pop != 0 && first_pop < 0) first_pop = cyc;
    if ((obs_v0 != 0 || obs_v1 != 0) && first_val < 0) first_val = cyc;
    if (obs_v0 != 0) v0_seen++;

    @(posedge clk);
    #1;
    cyc++;
    if (!r) begin
      model_reset();
      checking  = 1;
      fifo_data = 8'($urandom);
    end else begin
      m_v[0] = 0; m_v[1] = 0;
      while (dq.size() > 0 && dq[0].due == cyc) begin
        m_v[dq[0].lane] = 1;
        m_d[dq[0].lane] = dq[0].data;
        m_s[dq[0].lane] = (m_s[dq[0].lane] + 1) % 256;
        void'(dq.pop_front());
      end
      if (m_pop != 0) begin
        it.due  = cyc + 1;
        it.lane = m_lane;
        it.data = fifo_q.pop_front();
        fifo_data = it.data;
        dq.push_back(it);
        m_rr = 1 - m_lane;
      end else begin
        fifo_data = 8'($urandom);
      end
      case (m_state)
        0: if (e) m_state = 1;
        1: if (!e) m_state = 0;
           else if (!fifo_empty && f0 && f1) m_state = 2;
        2: if (!e) m_state = 0;
           else if (!f0 || !f1) m_state = 1;
        default: m_state = 0;
      endcase
    end
    @(negedge clk);
  endtask

  logic [7:0] last_word;

  initial begin
    reset = 1'b0; enable = 1'b0; fifo_empty = 1'b1;
    lane_full0 = 1'b0; lane_full1 = 1'b0; fifo_data = 8'h00;
    model_reset();
    first_pop = -1; first_val = -1; v0_seen = 0;
    @(negedge clk);

    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("rst_state", int'(state), 0);
    chk("rst_sent0", int'(sent0), 0);
    chk("rst_valid", int'(validOut0 | validOut1), 0);

    // Four words, both lanes free: alternate lanes starting at lane 0.
    fifo_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    first_pop = -1; first_val = -1;
    repeat (8) step(1, 1, 0, 0);
    chk("rr_sent0", int'(sent0), 2);
    chk("rr_sent1", int'(sent1), 2);
    chk("rr_data0", int'(dataOut0), 8'hC3);
    chk("rr_data1", int'(dataOut1), 8'hD4);
    chk("latency", first_val - first_pop, 2);

    // Lane 0 full: everything goes to lane 1.
    step(0, 0, 0, 0);
    fifo_q = '{8'h11, 8'h22};
    v0_seen = 0;
    repeat (7) step(1, 1, 1, 0);
    chk("l1_sent0", int'(sent0), 0);
    chk("l1_sent1", int'(sent1), 2);
    chk("l1_data1", int'(dataOut1), 8'h22);
    chk("l1_no_v0", v0_seen, 0);

    // Both lanes full -> STALL, then release lane 1.
    step(0, 0, 0, 0);
    fifo_q = '{8'h77};
    step(1, 1, 1, 1);
    step(1, 1, 1, 1);
    step(1, 1, 1, 1);
    chk("stall_state", obs_state, 2);
    chk("stall_pop", obs_pop, 0);
    step(1, 1, 1, 0);
    chk("stall_exit_pop", obs_pop, 1);
    step(1, 1, 1, 0);
    chk("stall_exit_state", obs_state, 1);
    step(1, 1, 1, 0);
    chk("stall_v1", obs_v1, 1);
    chk("stall_data1", int'(dataOut1), 8'h77);

    // Enable drops right after a pop: word still delivered.
    step(0, 0, 0, 0);
    fifo_q = '{8'h5A, 8'h6B};
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("drop_v0", obs_v0, 1);
    chk("drop_data0", int'(dataOut0), 8'h5A);
    chk("drop_state", obs_state, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0);
      chk("drop_no_pop", obs_pop, 0);
    end

    // Reset with a word in flight discards it.
    step(0, 0, 0, 0);
    fifo_q = '{8'h3C};
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    chk("rstpend_v", obs_v0 | obs_v1, 0);
    chk("rstpend_state", obs_state, 0);
    chk("rstpend_data0", int'(dataOut0), 0);
    chk("rstpend_sent0", int'(sent0), 0);

    // 257 words to lane 0: counter wraps to 1.
    step(0, 0, 0, 0);
    fifo_q.delete();
    for (int i = 0; i < 257; i++) begin
      last_word = 8'($urandom);
      fifo_q.push_back(last_word);
    end
    repeat (262) step(1, 1, 0, 1);
    chk("wrap_sent0", int'(sent0), 1);
    chk("wrap_data0", int'(dataOut0), int'(last_word));
    chk("wrap_sent1", int'(sent1), 0);

    // Randomized traffic against the model.
    step(0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 50 && fifo_q.size() < 16)
        fifo_q.push_back(8'($urandom));
      step($urandom_range(0, 39) != 0,
           $urandom_range(0, 99) < 85,
           $urandom_range(0, 99) < 30,
           $urandom_range(0, 99) < 30);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/demux_lane_sched.md
DEMUX_LANE_SCHED -- requirements
Module: demux_lane_sched

Interface
REQ-001 The block SHALL have input clk, 1 bit, the system clock; all state updates on its rising edge.
REQ-002 The block SHALL have input reset, 1 bit; reset is synchronous and active-low, and the clock is clk.
REQ-003 The block SHALL have input enable, 1 bit, which gates scheduling: 1 = run, 0 = hold.
REQ-004 The block SHALL have input fifo_empty, 1 bit, the upstream FIFO empty flag.
REQ-005 The block SHALL have input fifo_data, 8 bits, the upstream FIFO read data, valid the cycle after pop.
REQ-006 The block SHALL have output pop, 1 bit, the upstream FIFO read strobe (combinational).
REQ-007 The block SHALL have input lane_full0 and input lane_full1, 1 bit each, the downstream lane almost-full flags.
REQ-008 The block SHALL have output dataOut0 and output dataOut1, 8 bits each, the lane data (registered).
REQ-009 The block SHALL have output validOut0 and output validOut1, 1 bit each, the lane valids (registered).
REQ-010 The block SHALL have output state, 2 bits, encoded IDLE=00, ACTIVE=01, STALL=10.
REQ-011 The block SHALL have output sent0 and output sent1, 8 bits each, the per-lane accepted-word counters.

Function
REQ-012 The block SHALL hold a 1-bit round-robin pointer rr, which is 0 after reset.
REQ-013 The block SHALL compute grant lane g each cycle as follows:
- g = rr if lane_full[rr]=0;
- else g = ~rr if lane_full[~rr]=0;
- else no grant.
REQ-014 The block SHALL drive pop=1 exactly when enable=1, fifo_empty=0, reset=1 and a grant exists.
REQ-015 On a cycle with pop=1, the block SHALL register g as sel_d and set in-flight flag pend=1; otherwise it SHALL set pend=0.
REQ-016 On a cycle with pop=1, rr SHALL become ~g at the next edge; otherwise rr SHALL hold.
REQ-017 In a cycle with pend=1, the block SHALL register fifo_data into dataOut[sel_d] and set validOut[sel_d]=1 at the next edge.
REQ-018 Pop-to-valid latency SHALL be 2 clocks: pop in cycle N gives validOut in cycle N+2.
REQ-019 A lane not written in a cycle SHALL hold its dataOut and drive its validOut=0 in the next cycle.
REQ-020 validOut0 and validOut1 SHALL never be 1 in the same cycle.
REQ-021 sent[g] SHALL increment by 1 on each edge where validOut[g] is set, and SHALL wrap from 255 to 0.
REQ-022 State transitions SHALL be:
- IDLE->ACTIVE when enable=1;
- ACTIVE->IDLE when enable=0;
- ACTIVE->STALL when enable=1, fifo_empty=0 and both lane_full are 1;
- STALL->ACTIVE when either lane_full is 0;
- STALL->IDLE when enable=0.
REQ-023 pop SHALL be 0 in IDLE and STALL; grant evaluation SHALL use current inputs, so pop is allowed in the cycle STALL exits.
REQ-024 A word already popped (pend=1) SHALL be delivered to its lane even if lane_full rises or enable drops in the delivery cycle.
REQ-025 fifo_empty=1 in ACTIVE SHALL keep the block in ACTIVE with pop=0 and rr unchanged.

Reset
REQ-026 While reset=0 at an edge, the block SHALL set dataOut0=dataOut1=0x00, validOut0=validOut1=0, sent0=sent1=0, rr=0, pend=0, state=IDLE.
REQ-027 While reset=0, pop SHALL be 0.
REQ-028 A reset asserted with pend=1 SHALL discard the in-flight word: no validOut in the following cycle.
REQ-029 After reset is released, the first grant SHALL go to lane 0 if lane_full0=0.

Verification
REQ-030 enable=1, FIFO holds 0xA1,0xB2,0xC3,0xD4, lanes free -> pop 4 consecutive cycles; lane0 gets 0xA1,0xC3 and lane1 gets 0xB2,0xD4; first valid 2 clocks after first pop; sent0=sent1=2.
REQ-031 lane_full0=1, lane_full1=0, FIFO holds 0x11,0x22 -> both words go to lane1; sent0=0, sent1=2; validOut0 never 1.
REQ-032 Both lane_full=1 with FIFO non-empty -> state=STALL, pop=0; drop lane_full1 -> pop same cycle, word on lane1 2 clocks later, state=ACTIVE.
REQ-033 Pop 0x5A then drop enable the next cycle -> 0x5A still appears on the granted lane; state=IDLE; no further pop.
REQ-034 Assert reset in the cycle after a pop -> no validOut next cycle; all outputs 0; state=00.
REQ-035 Send 257 words all to lane0 (lane_full1=1) -> sent0 wraps to 1; dataOut0 equals the last word.
